alu_wb: RTL and testbench
=========================

ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 ex_valid  in  1  ALU result present this cycle; ex_ready  out  1  stage can accept.
REQ-004 alu_cmd  in  3  command that produced the result: 000 ADD, 001 LSH, 010 RSH, 011 NAND, 100 SUB, 101-111 reserved.
REQ-005 rslt  in  8, sc_o  in  1, zero  in  1, pari  in  1  ALU outputs.
REQ-006 dest  in  3  destination register; wr_en_i  in  1  instruction writes a register.
REQ-007 flag_clr  in  1  synchronous carry-flag clear request.
REQ-008 sc_i  out  1  registered carry flag, fed back to the ALU carry input.
REQ-009 zero_f, pari_f  out  1 each  registered zero and parity flags.
REQ-010 wb_valid  out  1, wb_ready  in  1, wb_addr  out  3, wb_data  out  8  register-file write handshake.
REQ-011 fwd_addr  in  3; fwd_hit  out  1; fwd_data  out  8  bypass of the pending write.
REQ-012 retire_cnt  out  8  count of completed register writes.

Function
REQ-013 ex_ready SHALL equal (state==EMPTY) or wb_ready, combinationally.
REQ-014 Accept SHALL mean ex_valid and ex_ready at a rising edge; no input is sampled otherwise.
REQ-015 State machine SHALL have two states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
REQ-016 EMPTY -> FULL on accept with wr_en_i=1; stays EMPTY on accept with wr_en_i=0 or no accept.
REQ-017 FULL -> EMPTY when wb_ready=1 and no accept with wr_en_i=1; FULL -> FULL with new data on drain plus accept with wr_en_i=1; FULL held unchanged while wb_ready=0.
REQ-018 On accept with wr_en_i=1, wb_data/wb_addr SHALL load rslt/dest, visible one cycle later (latency 1).
REQ-019 wb_data/wb_addr SHALL be stable while wb_valid=1 and wb_ready=0.
REQ-020 retire_cnt SHALL increment by 1 on each cycle with wb_valid and wb_ready, wrapping 255 -> 0.
REQ-021 Carry flag SHALL load sc_o on accept of ADD, LSH, RSH or SUB; NAND and reserved codes SHALL preserve it.
REQ-022 zero_f/pari_f SHALL load zero/pari on accept of codes 000-100; reserved codes SHALL preserve them.
REQ-023 Flags SHALL update on accept regardless of wr_en_i.
REQ-024 flag_clr SHALL clear the carry flag next cycle; on the same edge as a carry-updating accept, the accept SHALL win.
REQ-025 fwd_hit SHALL equal wb_valid and (fwd_addr==wb_addr); fwd_data SHALL equal wb_data; both combinational.

Reset
REQ-026 Reset SHALL asynchronously force state EMPTY, wb_valid=0, wb_data=0, wb_addr=0, sc_i=0, zero_f=0, pari_f=0, retire_cnt=0.
REQ-027 With reset high, ex_ready SHALL be 1 and fwd_hit 0; a pending write SHALL be discarded, not retired.
REQ-028 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package alu_pkg SHALL hold the alu_cmd enum (ADD, LSH, RSH, NAND, SUB), the EMPTY/FULL state enum and the data-width constant 8.
REQ-030 Flag logic (carry, zero, parity, clear priority) SHALL be one sub-module, alu_flags; the pipeline register and FSM stay in alu_wb.

Verification
REQ-031 ADD accept, rslt=8'hFF, sc_o=1, zero=0, pari=0, dest=3, wr_en_i=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=FF, wb_addr=3, sc_i=1; one cycle later retire_cnt=1.
REQ-032 wb_ready=0 with FULL holding 8'h12, new ex_valid -> ex_ready=0, wb_data stays 12 for 5 cycles; on wb_ready=1, drain and accept occur on the same edge, new data appears next cycle.
REQ-033 sc_i=1, then NAND accept with sc_o=0 -> sc_i stays 1; then flag_clr alone -> sc_i=0; flag_clr plus SUB accept with sc_o=1 -> sc_i=1.
REQ-034 FULL with wb_addr=5, wb_data=8'hA5: fwd_addr=5 -> fwd_hit=1, fwd_data=A5; fwd_addr=4 -> fwd_hit=0; EMPTY -> fwd_hit=0.
REQ-035 Reset asserted mid-cycle while FULL and wb_ready=0 -> wb_valid=0, sc_i=0 immediately without a clock edge; retire_cnt unchanged at 0.
REQ-036 256 retired writes with wb_ready=1 -> retire_cnt wraps to 0; reserved alu_cmd=3'b111 accept -> all flags unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU write-back stage.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_LSH  = 3'b001,
    CMD_RSH  = 3'b010,
    CMD_NAND = 3'b011,
    CMD_SUB  = 3'b100
  } alu_cmd_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_e;

  // NAND has no meaningful carry-out, so only arithmetic and shift commands touch carry.
  function automatic logic cmd_sets_carry(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_LSH) || (cmd == CMD_RSH) || (cmd == CMD_SUB);
  endfunction

  function automatic logic cmd_sets_zp(input logic [2:0] cmd);
    return cmd <= CMD_SUB;
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Carry, zero and parity flag registers; a carry-updating accept beats flag_clr.
module alu_flags
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic [2:0] alu_cmd,
  input  logic       sc_o,
  input  logic       zero,
  input  logic       pari,
  input  logic       flag_clr,
  output logic       sc_i,
  output logic       zero_f,
  output logic       pari_f
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_i   <= 1'b0;
      zero_f <= 1'b0;
      pari_f <= 1'b0;
    end else begin
      if (accept && cmd_sets_carry(alu_cmd)) begin
        sc_i <= sc_o;
      end else if (flag_clr) begin
        sc_i <= 1'b0;
      end
      if (accept && cmd_sets_zp(alu_cmd)) begin
        zero_f <= zero;
        pari_f <= pari;
      end
    end
  end

endmodule

// File: rtl/alu_wb.sv
// ALU write-back stage: one-entry pipeline register toward the register file,
// flag registers, forwarding of the pending write and a retire counter.
module alu_wb
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        alu_cmd,
  input  logic [DATA_W-1:0] rslt,
  input  logic              sc_o,
  input  logic              zero,
  input  logic              pari,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wr_en_i,
  input  logic              flag_clr,
  output logic              sc_i,
  output logic              zero_f,
  output logic              pari_f,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [7:0]        retire_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and payload is held while valid && !ready.
  wb_state_e state_q, state_d;
  logic      accept;
  logic      load;
  logic      drain;

  assign ex_ready = (state_q == EMPTY) || wb_ready;
  assign accept   = ex_valid && ex_ready;
  assign load     = accept && wr_en_i;
  assign drain    = (state_q == FULL) && wb_ready;
  assign wb_valid = (state_q == FULL);
  assign fwd_hit  = wb_valid && (fwd_addr == wb_addr);
  assign fwd_data = wb_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)          state_d = FULL;
        else if (wb_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_addr    <= '0;
      wb_data    <= '0;
      retire_cnt <= '0;
    end else begin
      if (load) begin
        wb_addr <= dest;
        wb_data <= rslt;
      end
      if (drain) retire_cnt <= retire_cnt + 8'd1;
    end
  end

  alu_flags u_flags (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept),
    .alu_cmd  (alu_cmd),
    .sc_o     (sc_o),
    .zero     (zero),
    .pari     (pari),
    .flag_clr (flag_clr),
    .sc_i     (sc_i),
    .zero_f   (zero_f),
    .pari_f   (pari_f)
  );

endmodule

// File: tb/tb_alu_wb.sv
// Bench for alu_wb: directed scenarios plus random traffic against a queue-based model.
module tb_alu_wb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0;
  logic       ex_ready;
  logic [2:0] alu_cmd = '0;
  logic [7:0] rslt = '0;
  logic       sc_o = 1'b0, zero = 1'b0, pari = 1'b0;
  logic [2:0] dest = '0;
  logic       wr_en_i = 1'b0;
  logic       flag_clr = 1'b0;
  logic       sc_i, zero_f, pari_f;
  logic       wb_valid;
  logic       wb_ready = 1'b0;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [2:0] fwd_addr = '0;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic [7:0] retire_cnt;

  int total = 0;
  int bad = 0;

  // model state
  logic [10:0] exp_q[$];
  logic        m_sc = 1'b0, m_z = 1'b0, m_p = 1'b0;
  logic [7:0]  m_ret = '0;
  logic [7:0]  m_wbd = '0;

  alu_wb dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_cmd(alu_cmd), .rslt(rslt), .sc_o(sc_o), .zero(zero), .pari(pari),
    .dest(dest), .wr_en_i(wr_en_i), .flag_clr(flag_clr), .sc_i(sc_i),
    .zero_f(zero_f), .pari_f(pari_f), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever a write-back transfer is about to complete
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", 1, 0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("wb_addr_xfer", int'(wb_addr), int'(e[10:8]));
        chk("wb_data_xfer", int'(wb_data), int'(e[7:0]));
        m_ret = m_ret + 8'd1;
      end
    end
  end

  // driver: one clock cycle of stimulus, checks of visible state, then model update
  task automatic cycle(input logic ev, input logic [2:0] cmd, input logic [7:0] r,
                       input logic co, input logic z, input logic p, input logic [2:0] d,
                       input logic wr, input logic clr, input logic wbr, input logic [2:0] fa);
    logic exp_rdy;
    logic acc;
    @(posedge clk);
    #1;
    ex_valid = ev; alu_cmd = cmd; rslt = r; sc_o = co; zero = z; pari = p;
    dest = d; wr_en_i = wr; flag_clr = clr; wb_ready = wbr; fwd_addr = fa;
    #2;
    exp_rdy = (exp_q.size() == 0) || wbr;
    chk("ex_ready", int'(ex_ready), int'(exp_rdy));
    chk("wb_valid", int'(wb_valid), int'(exp_q.size() > 0));
    chk("wb_data", int'(wb_data), int'(m_wbd));
    chk("fwd_data", int'(fwd_data), int'(m_wbd));
    if (exp_q.size() > 0) begin
      chk("wb_addr", int'(wb_addr), int'(exp_q[0][10:8]));
      chk("fwd_hit", int'(fwd_hit), int'(fa == exp_q[0][10:8]));
    end else begin
      chk("fwd_hit_empty", int'(fwd_hit), 0);
    end
    chk("sc_i", int'(sc_i), int'(m_sc));
    chk("zero_f", int'(zero_f), int'(m_z));
    chk("pari_f", int'(pari_f), int'(m_p));
    chk("retire_cnt", int'(retire_cnt), int'(m_ret));
    acc = ev && exp_rdy;
    if (acc && wr) begin
      exp_q.push_back({d, r});
      m_wbd = r;
    end
    if (acc && (cmd == 3'd0 || cmd == 3'd1 || cmd == 3'd2 || cmd == 3'd4)) m_sc = co;
    else if (clr) m_sc = 1'b0;
    if (acc && cmd <= 3'd4) begin
      m_z = z;
      m_p = p;
    end
  endtask

  task automatic idle(input logic wbr);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, wbr, 3'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ex_ready", int'(ex_ready), 1);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_fwd_hit", int'(fwd_hit), 0);
    chk("rst_retire", int'(retire_cnt), 0);
    reset = 1'b0;

    // pending write with carry set, then asynchronous reset mid-cycle
    cycle(1'b1, 3'd0, 8'h77, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd2);
    idle(1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst_wb_valid", int'(wb_valid), 0);
    chk("arst_sc_i", int'(sc_i), 0);
    chk("arst_zero_f", int'(zero_f), 0);
    chk("arst_wb_data", int'(wb_data), 0);
    chk("arst_ex_ready", int'(ex_ready), 1);
    chk("arst_fwd_hit", int'(fwd_hit), 0);
    chk("arst_retire", int'(retire_cnt), 0);
    exp_q.delete();
    m_sc = 0; m_z = 0; m_p = 0; m_ret = 0; m_wbd = 0;
    #2 reset = 1'b0;

    // ADD FF to r3 with carry
    cycle(1'b1, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 3'd3);
    idle(1'b1);
    idle(1'b1);

    // backpressure: hold 12 while a new request waits, then drain+accept same edge
    cycle(1'b1, 3'd4, 8'h12, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd1);
    repeat (5) cycle(1'b1, 3'd0, 8'h34, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 3'd6);
    cycle(1'b1, 3'd0, 8'h34, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 3'd6);
    idle(1'b1);
    idle(1'b1);

    // carry: NAND preserves, clr clears, clr+SUB loads
    cycle(1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    cycle(1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0);
    cycle(1'b1, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0);
    idle(1'b1);

    // forwarding with r5 = A5 pending
    cycle(1'b1, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd5);
    idle(1'b0);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4);
    idle(1'b1);
    cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5);

    // reserved command leaves every flag alone
    cycle(1'b1, 3'd1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    cycle(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0);
    idle(1'b1);

    // back-to-back writes past the counter wrap
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 3'd0, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0,
            3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)));

    // random traffic
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0),
            3'($urandom_range(0, 7)));

    repeat (3) idle(1'b1);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
